// File: rtl/switch_chain_sequencer.sv
// Select-line sequencer for a chained switch/mixer/heater/filter fluidic network:
// primes a source valve, steps each stage for its dwell time, then drains through the merge switch.
module switch_chain_sequencer #(
    parameter int NUM_CH       = 2,
    parameter int NUM_STAGES   = 5,
    parameter int DWELL_W      = 16,
    parameter int PRIME_CYCLES = 4,
    parameter int DRAIN_CYCLES = 8,
    parameter int CH_W         = (NUM_CH > 2) ? $clog2(NUM_CH) : 1,
    parameter int ST_W         = (NUM_STAGES > 2) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_we,
    input  logic [ST_W-1:0]         cfg_stage,
    input  logic [DWELL_W-1:0]      cfg_dwell,
    output logic                    cfg_err,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [CH_W-1:0]         req_ch,
    input  logic [2*NUM_STAGES-1:0] req_recipe,
    input  logic                    abort,
    output logic [NUM_CH-1:0]       valve_src,
    output logic [2*NUM_STAGES-1:0] stage_sel,
    output logic [CH_W-1:0]         merge_sel,
    output logic                    merge_en,
    output logic                    busy,
    output logic [ST_W-1:0]         cur_stage,
    output logic                    done,
    output logic                    rej
);

    localparam int PD_MAX = (PRIME_CYCLES > DRAIN_CYCLES) ? PRIME_CYCLES : DRAIN_CYCLES;
    localparam int PD_W   = $clog2(PD_MAX + 1);
    localparam int CNT_W  = (DWELL_W > PD_W) ? DWELL_W : PD_W;

    typedef enum logic [2:0] {S_IDLE, S_PRIME, S_STAGE, S_DRAIN, S_DONE} state_t;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [ST_W-1:0]         r_stage;
    logic [CH_W-1:0]         r_ch;
    logic [2*NUM_STAGES-1:0] r_recipe;
    logic [DWELL_W-1:0]      r_dwell [NUM_STAGES];

    logic                    r_cfg_err;
    logic                    r_req_ready;
    logic [NUM_CH-1:0]       r_valve_src;
    logic [2*NUM_STAGES-1:0] r_stage_sel;
    logic [CH_W-1:0]         r_merge_sel;
    logic                    r_merge_en;
    logic                    r_busy;
    logic [ST_W-1:0]         r_cur_stage;
    logic                    r_done;
    logic                    r_rej;

    logic [NUM_STAGES-1:0]   w_field_bad;
    logic [CNT_W-1:0]        w_len [NUM_STAGES];
    logic [31:0]             w_ch_ext;
    logic [31:0]             w_cfg_ext;
    logic                    w_req_bad;
    logic                    w_cfg_ok;
    logic [ST_W-1:0]         w_next_stage;
    logic                    w_last_stage;
    logic                    w_enter_drain;

    function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] c);
        return NUM_CH'(1) << c;
    endfunction

    function automatic logic [2*NUM_STAGES-1:0] sel_for(input logic [ST_W-1:0] k,
                                                        input logic [2*NUM_STAGES-1:0] rec);
        logic [2*NUM_STAGES-1:0] s;
        s = '0;
        for (int i = 0; i < NUM_STAGES; i++)
            if (k == ST_W'(i)) s[2*i +: 2] = rec[2*i +: 2];
        return s;
    endfunction

    // Per-stage hold length: bypass is one cycle, a zero dwell counts as one.
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
        assign w_field_bad[gi] = (req_recipe[2*gi +: 2] == 2'd3);
        assign w_len[gi] = (r_recipe[2*gi +: 2] == 2'd0 || r_dwell[gi] == '0)
                           ? CNT_W'(1) : CNT_W'(r_dwell[gi]);
    end

    assign w_ch_ext      = 32'(req_ch);
    assign w_cfg_ext     = 32'(cfg_stage);
    assign w_req_bad     = (|w_field_bad) || (w_ch_ext >= 32'(NUM_CH));
    assign w_cfg_ok      = (r_state == S_IDLE) && (w_cfg_ext < 32'(NUM_STAGES));
    assign w_next_stage  = r_stage + ST_W'(1);
    assign w_last_stage  = (r_stage == ST_W'(NUM_STAGES - 1));
    assign w_enter_drain = (abort && (r_state == S_PRIME || r_state == S_STAGE)) ||
                           (r_state == S_STAGE && r_cnt == CNT_W'(1) && w_last_stage);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STAGES; i++) r_dwell[i] <= DWELL_W'(1);
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we && !w_cfg_ok;
            if (cfg_we && w_cfg_ok)
                for (int i = 0; i < NUM_STAGES; i++)
                    if (cfg_stage == ST_W'(i)) r_dwell[i] <= cfg_dwell;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_stage     <= '0;
            r_ch        <= '0;
            r_recipe    <= '0;
            r_req_ready <= 1'b1;
            r_valve_src <= '0;
            r_stage_sel <= '0;
            r_merge_sel <= '0;
            r_merge_en  <= 1'b0;
            r_busy      <= 1'b0;
            r_cur_stage <= '0;
            r_done      <= 1'b0;
            r_rej       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_rej  <= 1'b0;
            if (w_enter_drain) begin
                r_state     <= S_DRAIN;
                r_cnt       <= CNT_W'(DRAIN_CYCLES);
                r_stage_sel <= '0;
                r_cur_stage <= '0;
                r_merge_en  <= 1'b1;
                r_merge_sel <= r_ch;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_req_ready <= 1'b1;
                        if (req_valid && r_req_ready) begin
                            r_ch        <= req_ch;
                            r_recipe    <= req_recipe;
                            r_req_ready <= 1'b0;
                            if (w_req_bad) begin
                                r_rej <= 1'b1;
                            end else begin
                                r_state     <= S_PRIME;
                                r_cnt       <= CNT_W'(PRIME_CYCLES);
                                r_busy      <= 1'b1;
                                r_valve_src <= onehot(req_ch);
                            end
                        end
                    end
                    S_PRIME: begin
                        if (r_cnt == CNT_W'(1)) begin
                            r_state     <= S_STAGE;
                            r_stage     <= '0;
                            r_cnt       <= w_len[0];
                            r_stage_sel <= sel_for('0, r_recipe);
                            r_cur_stage <= '0;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    S_STAGE: begin
                        if (r_cnt == CNT_W'(1)) begin
                            r_stage     <= w_next_stage;
                            r_cnt       <= w_len[w_next_stage];
                            r_stage_sel <= sel_for(w_next_stage, r_recipe);
                            r_cur_stage <= w_next_stage;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    S_DRAIN: begin
                        if (r_cnt == CNT_W'(1)) begin
                            r_state     <= S_DONE;
                            r_done      <= 1'b1;
                            r_valve_src <= '0;
                            r_merge_en  <= 1'b0;
                            r_merge_sel <= '0;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    S_DONE: begin
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign cfg_err   = r_cfg_err;
    assign req_ready = r_req_ready;
    assign valve_src = r_valve_src;
    assign stage_sel = r_stage_sel;
    assign merge_sel = r_merge_sel;
    assign merge_en  = r_merge_en;
    assign busy      = r_busy;
    assign cur_stage = r_cur_stage;
    assign done      = r_done;
    assign rej       = r_rej;

endmodule

// File: tb/tb_switch_chain_sequencer.sv
// Randomized bench for switch_chain_sequencer: each run is predicted as a cycle-by-cycle
// output timeline assembled from prime/stage/drain segment lengths.
module tb_switch_chain_sequencer;

    localparam int NCH = 2, NST = 5, DW = 16, PRIME = 4, DRAIN = 8, CH_W = 1, ST_W = 3;

    typedef struct packed {
        logic [NCH-1:0]   valve;
        logic [2*NST-1:0] sel;
        logic [CH_W-1:0]  msel;
        logic             men;
        logic             busy;
        logic             done;
        logic             ready;
        logic             rej;
        logic             cerr;
    } obs_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             cfg_we = 1'b0;
    logic [ST_W-1:0]  cfg_stage = '0;
    logic [DW-1:0]    cfg_dwell = '0;
    logic             cfg_err;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [CH_W-1:0]  req_ch = '0;
    logic [2*NST-1:0] req_recipe = '0;
    logic             abort = 1'b0;
    logic [NCH-1:0]   valve_src;
    logic [2*NST-1:0] stage_sel;
    logic [CH_W-1:0]  merge_sel;
    logic             merge_en;
    logic             busy;
    logic [ST_W-1:0]  cur_stage;
    logic             done;
    logic             rej;

    int   n_checks = 0;
    int   n_errors = 0;
    int   dw [NST];
    obs_t exp_q [$];
    int   stg_q [$];

    switch_chain_sequencer #(
        .NUM_CH(NCH), .NUM_STAGES(NST), .DWELL_W(DW),
        .PRIME_CYCLES(PRIME), .DRAIN_CYCLES(DRAIN), .CH_W(CH_W), .ST_W(ST_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_stage(cfg_stage), .cfg_dwell(cfg_dwell), .cfg_err(cfg_err),
        .req_valid(req_valid), .req_ready(req_ready), .req_ch(req_ch), .req_recipe(req_recipe),
        .abort(abort), .valve_src(valve_src), .stage_sel(stage_sel), .merge_sel(merge_sel),
        .merge_en(merge_en), .busy(busy), .cur_stage(cur_stage), .done(done), .rej(rej)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.valve = valve_src; o.sel = stage_sel; o.msel = merge_sel; o.men = merge_en;
        o.busy = busy; o.done = done; o.ready = req_ready; o.rej = rej; o.cerr = cfg_err;
        return o;
    endfunction

    function automatic obs_t mk(input logic von, input logic [CH_W-1:0] ch,
                                input logic [2*NST-1:0] sel, input logic men, input logic bsy,
                                input logic dn, input logic rdy, input logic rj);
        obs_t o;
        o.valve = von ? (NCH'(1) << ch) : '0;
        o.sel = sel; o.msel = men ? ch : '0; o.men = men;
        o.busy = bsy; o.done = dn; o.ready = rdy; o.rej = rj; o.cerr = 1'b0;
        return o;
    endfunction

    function automatic obs_t idle_obs();
        return mk(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endfunction

    task automatic cfg_write(input int st, input int val);
        cfg_we = 1'b1; cfg_stage = ST_W'(st); cfg_dwell = DW'(val);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        check($sformatf("cfg_err st=%0d", st), 64'(cfg_err), 64'(st >= NST));
        if (st < NST) dw[st] = val;
        @(posedge clk); #1;
        check("cfg_err_clr", 64'(cfg_err), 64'(0));
        $display("cfg stage=%0d dwell=%0d", st, val);
    endtask

    // One request; sim_stage>=0 adds a cfg write in the accept cycle, cfg_at a write while busy.
    task automatic run(input logic [CH_W-1:0] ch, input logic [2*NST-1:0] rec, input int abort_at_in,
                       input int cfg_at_in, input int sim_stage, input int sim_val);
        int   abort_at, cfg_at, len, f;
        logic bad;
        logic [2*NST-1:0] sel;
        obs_t t;
        abort_at = abort_at_in; cfg_at = cfg_at_in;
        bad = 1'b0;
        for (int k = 0; k < NST; k++) if (rec[2*k +: 2] == 2'd3) bad = 1'b1;
        req_valid = 1'b1; req_ch = ch; req_recipe = rec;
        if (sim_stage >= 0) begin
            cfg_we = 1'b1; cfg_stage = ST_W'(sim_stage); cfg_dwell = DW'(sim_val);
            if (sim_stage < NST) dw[sim_stage] = sim_val;
        end
        exp_q.delete(); stg_q.delete();
        if (bad) begin
            exp_q.push_back(mk(1'b0, ch, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)); stg_q.push_back(-1);
            exp_q.push_back(idle_obs()); stg_q.push_back(-1);
            abort_at = 0; cfg_at = 0;
        end else begin
            for (int p = 0; p < PRIME; p++) begin
                exp_q.push_back(mk(1'b1, ch, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)); stg_q.push_back(-1);
            end
            for (int k = 0; k < NST; k++) begin
                f = int'(rec[2*k +: 2]);
                len = (f == 0) ? 1 : ((dw[k] == 0) ? 1 : dw[k]);
                sel = '0; sel[2*k +: 2] = 2'(f);
                for (int c = 0; c < len; c++) begin
                    exp_q.push_back(mk(1'b1, ch, sel, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)); stg_q.push_back(k);
                end
            end
            if (abort_at > exp_q.size()) abort_at = 0;
            if (abort_at > 0)
                while (exp_q.size() > abort_at) begin
                    void'(exp_q.pop_back()); void'(stg_q.pop_back());
                end
            for (int d = 0; d < DRAIN; d++) begin
                exp_q.push_back(mk(1'b1, ch, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)); stg_q.push_back(-1);
            end
            exp_q.push_back(mk(1'b0, ch, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)); stg_q.push_back(-1);
            exp_q.push_back(idle_obs()); stg_q.push_back(-1);
            if (cfg_at >= exp_q.size()) cfg_at = 0;
        end
        if (sim_stage >= NST) begin t = exp_q[0]; t.cerr = 1'b1; exp_q[0] = t; end
        if (cfg_at > 0) begin t = exp_q[cfg_at]; t.cerr = 1'b1; exp_q[cfg_at] = t; end
        for (int i = 1; i <= exp_q.size(); i++) begin
            @(posedge clk); #1;
            req_valid = 1'b0; cfg_we = 1'b0; abort = 1'b0;
            check($sformatf("cyc%0d", i), 64'(sample()), 64'(exp_q[i-1]));
            if (stg_q[i-1] >= 0)
                check($sformatf("cur_stage cyc%0d", i), 64'(cur_stage), 64'(stg_q[i-1]));
            if (i == abort_at) abort = 1'b1;
            if (i == cfg_at) begin
                cfg_we = 1'b1;
                cfg_stage = ST_W'($urandom_range(0, 7));
                cfg_dwell = DW'($urandom_range(0, 100));
            end
        end
        abort = 1'b0; cfg_we = 1'b0;
        $display("run ch=%0d recipe=0x%03h abort_at=%0d cfg_at=%0d rej=%0d cycles=%0d",
                 ch, rec, abort_at, cfg_at, bad, exp_q.size());
    endtask

    initial begin
        logic [2*NST-1:0] rec;
        int b;
        for (int k = 0; k < NST; k++) dw[k] = 1;

        #2 rst_n = 1'b0;
        #1 check("reset_asserted", 64'(sample()), 64'(idle_obs()));
        check("reset_cur_stage", 64'(cur_stage), 64'(0));
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("after_release", 64'(sample()), 64'(idle_obs()));

        run(1'b0, 10'h155, 0, 0, -1, 0);

        cfg_write(0, 3); cfg_write(1, 0); cfg_write(2, 5); cfg_write(3, 2); cfg_write(4, 1);
        run(1'b1, 10'h261, 0, 0, -1, 0);
        run(1'b0, 10'h0C0, 0, 0, -1, 0);
        run(1'b1, 10'h261, 10, 0, -1, 0);
        run(1'b0, 10'h261, 0, 12, -1, 0);
        cfg_write(7, 9);
        run(1'b1, 10'h261, 0, 0, 2, 4);

        req_valid = 1'b1; req_ch = 1'b1; req_recipe = 10'h2AA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (PRIME + 1) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("reset_mid_stage", 64'(sample()), 64'(idle_obs()));
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int k = 0; k < NST; k++) dw[k] = 1;
        @(posedge clk); #1;
        check("after_mid_reset", 64'(sample()), 64'(idle_obs()));
        run(1'b1, 10'h2AA, 0, 0, -1, 0);

        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 1) == 0)
                cfg_write($urandom_range(0, 7), $urandom_range(0, 6));
            rec = '0;
            for (int k = 0; k < NST; k++) rec[2*k +: 2] = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 4) == 0) begin
                b = $urandom_range(0, NST - 1);
                rec[2*b +: 2] = 2'd3;
            end
            run(CH_W'($urandom_range(0, NCH - 1)), rec,
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : 0,
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : 0,
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : -1,
                $urandom_range(0, 6));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/switch_chain_sequencer.md
# switch_chain_sequencer

Sequential controller for the switch-tree fluidic networks: it drives the select lines of a parametrised chain of routing switches that carries one of NUM_CH sources through NUM_STAGES processing stages (mixer/heater/filter pairs) to a shared merge switch and out. A run is started by a valid/ready request carrying a per-stage route recipe. Each stage is held for a programmable dwell time, and then the sample is drained through the merge switch. It replaces hand-sequenced valve control for the chained Switch/Mixer/Heater/Filter topologies.

## Interface
Parameters:
- NUM_CH, 2, number of source channels (≥2); CH_W = max(1, clog2(NUM_CH))
- NUM_STAGES, 5, switches per channel chain (≥1); ST_W = max(1, clog2(NUM_STAGES))
- DWELL_W, 16, dwell counter width
- PRIME_CYCLES, 4, source-valve prime time (≥1)
- DRAIN_CYCLES, 8, merge/drain time (≥1)

Ports (reset is asynchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  dwell register write strobe
- cfg_stage  in  ST_W  dwell register index
- cfg_dwell  in  DWELL_W  dwell value in cycles
- cfg_err  out  1  one-cycle pulse when a write is dropped
- req_valid  in  1  run request
- req_ready  out  1  high only in IDLE
- req_ch  in  CH_W  source channel
- req_recipe  in  2*NUM_STAGES  per-stage select; field k = bits [2k+1:2k]; 0 = bypass, 1 = unit A, 2 = unit B, 3 = illegal
- abort  in  1  level; forces DRAIN from PRIME or STAGE
- valve_src  out  NUM_CH  one-hot source valve enable
- stage_sel  out  2*NUM_STAGES  switch selects, same encoding as the recipe
- merge_sel  out  CH_W  merge switch channel
- merge_en  out  1  merge switch open to Out
- busy  out  1  not IDLE
- cur_stage  out  ST_W  index of the active stage
- done  out  1  one-cycle pulse, run completed
- rej  out  1  one-cycle pulse, request rejected

## Operation
- States: IDLE, PRIME, STAGE, DRAIN, DONE.
- Dwell registers: NUM_STAGES × DWELL_W.
  - Reset value is 1.
  - A write happens when cfg_we is high and the state is IDLE.
  - A write in any other state, or with cfg_stage ≥ NUM_STAGES, is dropped and pulses cfg_err.
  - A dwell value of 0 is treated as 1.
- IDLE:
  - A request is accepted when req_valid && req_ready.
  - req_ch and req_recipe are latched on acceptance.
  - If any recipe field is 3, or req_ch ≥ NUM_CH, the block pulses rej the next cycle and stays in IDLE. No valve opens.
  - Otherwise the next state is PRIME.
- PRIME:
  - valve_src = one-hot(ch); all other outputs stay at idle values.
  - Lasts PRIME_CYCLES, then STAGE with k = 0.
- STAGE k:
  - Field k of stage_sel = recipe[k]; fields 0..k-1 = 0 (bypass, pass-through); fields above k = 0.
  - A bypass stage (recipe 0) lasts exactly 1 cycle.
  - Any other stage lasts dwell[k] cycles.
  - When stage k ends: if k = NUM_STAGES-1 the next state is DRAIN, else k+1.
- DRAIN:
  - stage_sel = 0, merge_en = 1, merge_sel = ch, valve_src = one-hot(ch).
  - Lasts DRAIN_CYCLES, then DONE.
- DONE:
  - done = 1 for one cycle; all valves close; next state is IDLE.
- abort:
  - Sampled high in PRIME or STAGE: the next state is DRAIN. The drain cycle count restarts.
  - done still pulses after an aborted drain.
  - abort is ignored in IDLE, DRAIN and DONE.
- valve_src stays asserted in PRIME, STAGE and DRAIN.
- A simultaneous cfg_we and accepted req_valid in IDLE both take effect. The dwell write lands before the STAGE state reads it.

## Timing
- All outputs are registered.
- Reset values: valve_src = 0, stage_sel = 0, merge_sel = 0, merge_en = 0, busy = 0, cur_stage = 0, done = 0, rej = 0, cfg_err = 0, req_ready = 1, dwell regs = 1, state = IDLE.
- Accept at edge T:
  - busy and valve_src rise at T+1.
  - STAGE 0 outputs appear at T+1+PRIME_CYCLES.
- Total run length from accept to done (exclusive) = PRIME_CYCLES + Σ(stage durations) + DRAIN_CYCLES cycles, plus 1 cycle for DONE.
- req_ready falls in the cycle after acceptance. It rises again in the cycle after DONE, or in the cycle after rej.
- Dwell counter: loads on stage entry and decrements to 1. There is no wrap; DWELL_W bounds the maximum dwell.
- rst_n low at any time clears all state and outputs immediately (asynchronous). Release is synchronous to clk; no run resumes after reset.

## Test plan
- Reset with all parameters at default, then release → req_ready = 1, all other outputs 0; a read-back run confirms every dwell register is 1.
- Write dwell = {3, 0, 5, 2, 1}, then request ch = 1, recipe = {1, 0, 2, 1, 2} → busy for 4 + (3+1+5+2+1) + 8 = 24 cycles, done pulses at cycle 25. stage_sel field 2 = 2 for exactly 5 cycles; merge_sel = 1 during DRAIN.
- Request with recipe field 3 = 3 → rej pulse one cycle after accept, valve_src never asserts, req_ready returns to 1.
- abort raised in stage 2 of a run → next cycle is DRAIN with merge_en = 1 for 8 cycles, then done; stages 3 and 4 never select.
- cfg_we issued while busy, and cfg_we with cfg_stage = 7 → cfg_err pulses each time; dwell values are unchanged.
- rst_n asserted mid-STAGE → all outputs 0 immediately; after release req_ready = 1 and a new run completes normally.
